// File: rtl/vm1_pkg.sv
// Shared VM1 definitions: PSW bit positions, writeback FSM states and PSW reset value.
package vm1_pkg;

  localparam int unsigned PSW_C      = 0;
  localparam int unsigned PSW_V      = 1;
  localparam int unsigned PSW_Z      = 2;
  localparam int unsigned PSW_N      = 3;
  localparam int unsigned PSW_T      = 4;
  localparam int unsigned PSW_PRI_LO = 5;
  localparam int unsigned PSW_PRI_HI = 7;

  localparam logic [7:0] PSW_RESET = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REG_WR = 2'd1,
    BUS_WR = 2'd2
  } wb_state_e;

endpackage

// File: rtl/vm1_wb_merge.sv
// Byte merge for register writes and byte-lane steering for bus writes.
module vm1_wb_merge (
  input  logic        byte_op,
  input  logic        is_movb,
  input  logic [15:0] result,
  input  logic [15:0] dst_old,
  output logic [15:0] rf_wdata,
  output logic [15:0] bus_wdata
);

  always_comb begin
    rf_wdata  = result;
    bus_wdata = result;
    // MOVB writes the sign-extended word; other byte ops keep the old high byte.
    if (byte_op && !is_movb) rf_wdata = {dst_old[15:8], result[7:0]};
    // Byte data is replicated so either lane is correct regardless of address parity.
    if (byte_op) bus_wdata = {result[7:0], result[7:0]};
  end

endmodule

// File: rtl/vm1_alu_writeback.sv
// VM1 ALU writeback stage: PSW condition-code commit, register or bus result write.
// Optional bus_ack timeout enabled by defining VM1_WB_TIMEOUT_EN.
module vm1_alu_writeback
  import vm1_pkg::*;
#(
  parameter logic [7:0]  PSW_RESET      = vm1_pkg::PSW_RESET,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [15:0] result,
  input  logic [3:0]  flags,
  input  logic [3:0]  ccmask,
  input  logic        cc,
  input  logic        byte_op,
  input  logic        wr_dest,
  input  logic        dst_is_reg,
  input  logic [2:0]  dst_reg,
  input  logic [15:0] dst_old,
  input  logic        is_movb,
  input  logic [15:0] dst_addr,
  input  logic        psw_load,
  input  logic [7:0]  psw_in,
  output logic [7:0]  psw,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_byte,
  input  logic        bus_ack,
  output logic        bus_err
);

  wb_state_e   state_q, state_d;
  logic        accept;
  logic        timeout;
  logic [7:0]  psw_q;
  logic [2:0]  waddr_q;
  logic [15:0] rf_data_q, bus_data_q, addr_q;
  logic        byte_q;
  logic [15:0] rf_merge, bus_merge;

  assign accept = alu_valid && alu_ready;

  vm1_wb_merge u_merge (
    .byte_op   (byte_op),
    .is_movb   (is_movb),
    .result    (result),
    .dst_old   (dst_old),
    .rf_wdata  (rf_merge),
    .bus_wdata (bus_merge)
  );

`ifdef VM1_WB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       err_q;

  assign timeout = (state_q == BUS_WR) && !bus_ack && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q != BUS_WR) cnt_q <= '0;
      else if (!bus_ack)     cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus_err = err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && wr_dest) state_d = dst_is_reg ? REG_WR : BUS_WR;
      REG_WR:  state_d = IDLE;
      BUS_WR:  if (bus_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A PSW load wins over the ALU condition-code update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      psw_q <= PSW_RESET;
    end else if (psw_load) begin
      psw_q <= psw_in;
    end else if (accept && cc) begin
      psw_q[PSW_N:PSW_C] <= (psw_q[PSW_N:PSW_C] & ~ccmask) | (flags & ccmask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q    <= '0;
      rf_data_q  <= '0;
      bus_data_q <= '0;
      addr_q     <= '0;
      byte_q     <= 1'b0;
    end else if (accept) begin
      waddr_q    <= dst_reg;
      rf_data_q  <= rf_merge;
      bus_data_q <= bus_merge;
      addr_q     <= dst_addr;
      byte_q     <= byte_op;
    end
  end

  always_comb begin
    alu_ready = (state_q == IDLE);
    rf_we     = (state_q == REG_WR);
    bus_req   = (state_q == BUS_WR);
    rf_waddr  = rf_we   ? waddr_q    : '0;
    rf_wdata  = rf_we   ? rf_data_q  : '0;
    bus_addr  = bus_req ? addr_q     : '0;
    bus_wdata = bus_req ? bus_data_q : '0;
    bus_byte  = bus_req ? byte_q     : 1'b0;
  end

  assign psw = psw_q;

endmodule

// File: tb/tb_vm1_alu_writeback.sv
// Directed bench for vm1_alu_writeback: vector table for register/no-write ops plus bus sequences.
module tb_vm1_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [3:0]  ccmask;
  logic        cc;
  logic        byte_op;
  logic        wr_dest;
  logic        dst_is_reg;
  logic [2:0]  dst_reg;
  logic [15:0] dst_old;
  logic        is_movb;
  logic [15:0] dst_addr;
  logic        psw_load;
  logic [7:0]  psw_in;
  logic [7:0]  psw;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_byte;
  logic        bus_ack;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vm1_alu_writeback #(.PSW_RESET(8'hE0), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .result     (result),
    .flags      (flags),
    .ccmask     (ccmask),
    .cc         (cc),
    .byte_op    (byte_op),
    .wr_dest    (wr_dest),
    .dst_is_reg (dst_is_reg),
    .dst_reg    (dst_reg),
    .dst_old    (dst_old),
    .is_movb    (is_movb),
    .dst_addr   (dst_addr),
    .psw_load   (psw_load),
    .psw_in     (psw_in),
    .psw        (psw),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byte   (bus_byte),
    .bus_ack    (bus_ack),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic        cc;
    logic [3:0]  ccmask;
    logic [3:0]  flags;
    logic        byte_op;
    logic        is_movb;
    logic        wr_dest;
    logic [2:0]  dst_reg;
    logic [15:0] dst_old;
    logic [15:0] result;
    logic        psw_load;
    logic [7:0]  psw_in;
    logic [7:0]  exp_psw;
    logic        exp_we;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid  = 1'b0;
    result     = '0;
    flags      = '0;
    ccmask     = '0;
    cc         = 1'b0;
    byte_op    = 1'b0;
    wr_dest    = 1'b0;
    dst_is_reg = 1'b0;
    dst_reg    = '0;
    dst_old    = '0;
    is_movb    = 1'b0;
    dst_addr   = '0;
    psw_load   = 1'b0;
    psw_in     = '0;
  endtask

  // Launch a memory write; returns #1 after the accepting edge with alu_valid dropped.
  task automatic start_bus(input logic [15:0] res, input logic [15:0] addr, input logic b,
                           input logic mv, input logic c, input logic [3:0] m, input logic [3:0] f);
    result = res; dst_addr = addr; byte_op = b; is_movb = mv;
    cc = c; ccmask = m; flags = f;
    wr_dest = 1'b1; dst_is_reg = 1'b0; alu_valid = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // cc ccmask flags byte movb wr reg dst_old result load psw_in | psw we wdata
    vecs[0] = '{1'b1, 4'hF, 4'b1010, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0000, 16'h8001, 1'b0, 8'h00, 8'hEA, 1'b1, 16'h8001};
    vecs[1] = '{1'b1, 4'hF, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'hE1, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 4'hE, 4'b0101, 1'b1, 1'b0, 1'b1, 3'd2, 16'h12FF, 16'h0000, 1'b0, 8'h00, 8'hE5, 1'b1, 16'h1200};
    vecs[3] = '{1'b1, 4'hE, 4'b1000, 1'b1, 1'b1, 1'b1, 3'd5, 16'h1234, 16'hFF80, 1'b0, 8'h00, 8'hE9, 1'b1, 16'hFF80};
    vecs[4] = '{1'b0, 4'hF, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd7, 16'h0000, 16'hABCD, 1'b0, 8'h00, 8'hE9, 1'b1, 16'hABCD};
    vecs[5] = '{1'b1, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0000, 16'h1234, 1'b0, 8'h00, 8'hE9, 1'b1, 16'h0034};
    vecs[6] = '{1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0000, 16'h5555, 1'b1, 8'h0F, 8'h0F, 1'b1, 16'h5555};
    vecs[7] = '{1'b1, 4'h5, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h0A, 1'b0, 16'h0000};

    idle_inputs();
    bus_ack = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_psw", psw, 8'hE0);
    chk("reset_ready", alu_ready, 1'b1);
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_bus_req", bus_req, 1'b0);
    chk("reset_bus_err", bus_err, 1'b0);
    chk("reset_bus_wdata", bus_wdata, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      cc = vecs[i].cc; ccmask = vecs[i].ccmask; flags = vecs[i].flags;
      byte_op = vecs[i].byte_op; is_movb = vecs[i].is_movb; wr_dest = vecs[i].wr_dest;
      dst_is_reg = 1'b1; dst_reg = vecs[i].dst_reg; dst_old = vecs[i].dst_old;
      result = vecs[i].result; psw_load = vecs[i].psw_load; psw_in = vecs[i].psw_in;
      alu_valid = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("v%0d_psw", i), psw, vecs[i].exp_psw);
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("v%0d_ready", i), alu_ready, !vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_waddr", i), rf_waddr, vecs[i].dst_reg);
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
        @(posedge clk); #1;
        chk($sformatf("v%0d_we_drop", i), rf_we, 1'b0);
      end
    end

    // MOVB to odd address, ack in the fifth request cycle.
    start_bus(16'hFF80, 16'h1001, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    chk("movb_addr", bus_addr, 16'h1001);
    chk("movb_wdata", bus_wdata, 16'h8080);
    chk("movb_byte", bus_byte, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("movb_req_c%0d", c), bus_req, 1'b1);
      chk($sformatf("movb_ready_c%0d", c), alu_ready, 1'b0);
      chk($sformatf("movb_wdata_c%0d", c), bus_wdata, 16'h8080);
      if (c == 4) bus_ack = 1'b1;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    chk("movb_req_drop", bus_req, 1'b0);
    chk("movb_ready_after", alu_ready, 1'b1);
    chk("movb_psw_kept", psw, 8'h0A);

    // Word write acked in its first cycle; then a stray ack while idle.
    start_bus(16'h1234, 16'h2000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("word_wdata", bus_wdata, 16'h1234);
    chk("word_byte", bus_byte, 1'b0);
    chk("word_addr", bus_addr, 16'h2000);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("word_req_drop", bus_req, 1'b0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("idle_ack_req", bus_req, 1'b0);
    chk("idle_ack_ready", alu_ready, 1'b1);

    // Reset while a bus write is waiting.
    start_bus(16'h4321, 16'h3000, 1'b0, 1'b0, 1'b1, 4'hF, 4'b0110);
    chk("rst_mid_psw_pre", psw, 8'h06);
    chk("rst_mid_req_pre", bus_req, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_req", bus_req, 1'b0);
    chk("rst_mid_psw", psw, 8'hE0);
    chk("rst_mid_ready", alu_ready, 1'b1);

`ifdef VM1_WB_TIMEOUT_EN
    begin
      int n = 0;
      start_bus(16'h0001, 16'h4000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      while (bus_req && n < 200) begin
        chk("to_err_quiet", bus_err, 1'b0);
        n++;
        @(posedge clk); #1;
      end
      chk("to_req_cycles", n, 64);
      chk("to_err_pulse", bus_err, 1'b1);
      chk("to_ready", alu_ready, 1'b1);
      chk("to_psw", psw, 8'hE0);
      @(posedge clk); #1;
      chk("to_err_end", bus_err, 1'b0);
    end
`else
    start_bus(16'h0001, 16'h4000, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (70) @(posedge clk);
    #1;
    chk("noto_req_held", bus_req, 1'b1);
    chk("noto_err", bus_err, 1'b0);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("noto_req_drop", bus_req, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
